hazard_forward_ctrl: RTL
========================

// Module: hazard_forward_ctrl
// PURPOSE
//  Parametrised successor to the pipeline forwarding logic. Keeps a shadow pipeline of in-flight
//  destination registers, so forwarding and hazard decisions come from registered state.
//  Produces per-operand EX bypass selects over FWD_DEPTH producer stages, a load-use stall and a
//  store-data bypass. Sits beside the ID/EX control path; its selects drive the EX operand muxes.
// PARAMETERS
//  NUM_SRC     2  source operands per instruction (index 0 = rs, 1 = rt)
//  FWD_DEPTH   2  producer stages after EX able to forward (1 = EX/MEM, 2 = MEM/WB, ...)
//  LOAD_LAT    1  stages past EX before load data exists; a load in stage k <= LOAD_LAT cannot forward
//  RA_W        5  register address width
//  SEL_W       $clog2(FWD_DEPTH+1)  width of each forward select
// PORTS
//  clk           in   1               clock; all state updates on rising edge
//  rst           in   1               synchronous, active-high reset
//  id_valid      in   1               ID-stage instruction is real (not a bubble)
//  id_src        in   NUM_SRC*RA_W    ID source registers; operand i = id_src[i*RA_W +: RA_W]
//  id_src_used   in   NUM_SRC         operand i is actually read
//  id_rd         in   RA_W            ID destination register
//  id_regwrite   in   1               ID instruction writes id_rd
//  id_memtoreg   in   1               ID instruction is a load
//  id_memwrite   in   1               ID instruction is a store; store data = operand 1
//  ext_stall     in   1               whole pipeline frozen (memory wait)
//  flush         in   1               kill the ID instruction (branch taken)
//  fwd_sel       out  NUM_SRC*SEL_W   EX operand i source: 0 = regfile, k = producer stage k
//  hazard_stall  out  1               hold PC/IF/ID; bubble into EX
//  mem_wdata_fwd out  1               replace EX/MEM store data with MEM/WB load data
// BEHAVIOUR
//  - State: stage 0 (ID/EX) holds {valid, src[], used[], rd, regwrite, memtoreg, memwrite}.
//    Stages 1..FWD_DEPTH hold {valid, rd, regwrite, memtoreg, memwrite}.
//  - rst: clear every valid bit. While rst = 1, all outputs are forced to 0.
//  - Per edge, highest priority first:
//    ext_stall = 1: all stages hold.
//    Otherwise stage k <= stage k-1 for k >= 1.
//    Stage 0 <= bubble (valid = 0) if flush, hazard_stall or !id_valid; else it captures the ID inputs.
//  - fwd_sel[i] is combinational from registered state and valid while the instruction is in stage 0.
//    It is the smallest k in 1..FWD_DEPTH where stage k is valid, regwrite = 1, rd != 0,
//    rd == stage0.src[i], and used[i] = 1. If there is no such k, fwd_sel[i] = 0.
//    It is also 0 when stage 0 is invalid. The youngest producer always wins.
//  - hazard_stall = id_valid & !flush & !ext_stall, and some i with id_src_used[i] and a stage
//    j in 0..LOAD_LAT-1 that is valid, memtoreg = 1, rd != 0, rd == id_src[i].
//    Exception: a store's operand 1 matching only the stage-0 load does NOT stall; it uses
//    mem_wdata_fwd instead.
//  - mem_wdata_fwd = 1 when stage1 is a valid store, stage2 is a valid load with rd != 0, and
//    stage2.rd equals the store's src[1] (src[1] is carried into stage 1 for this purpose).
//  - Register 0 never forwards and never stalls.
//  - A flush in the same cycle as a hazard suppresses the stall; the killed instruction is not held.
//  - ext_stall during a hazard: hazard_stall reads 0, state is frozen, and the hazard is
//    re-evaluated on release.
//  - The block never selects a load stage k <= LOAD_LAT. If it does, that is a design error,
//    and the bench asserts against it.
// STRUCTURE
//  - Shared header hazard_defs.vh: localparams FWD_REGFILE = 0, FWD_EXMEM = 1, FWD_MEMWB = 2,
//    and the stage-record field widths.
//  - One sub-module, hazard_stage_reg: a single shadow-stage register with hold, bubble-insert
//    and rst. It is instantiated FWD_DEPTH+1 times by a generate loop.
//  - Priority match: a generate loop per operand.
// TESTING
//  - Back-to-back ALU ops: add r3 <- r1,r2 ; sub r4 <- r3,r3
//    -> fwd_sel = {1,1} in sub's EX cycle, no stall.
//  - Distance 2: add r3 ; nop ; or r5 <- r3,r0
//    -> fwd_sel[0] = 2, fwd_sel[1] = 0 (r0 is never forwarded).
//  - Load-use: lw r7 ; add r8 <- r7,r1
//    -> hazard_stall = 1 for exactly one cycle, one bubble enters EX, then fwd_sel[0] = 2.
//  - Load then store: lw r9 ; sw r9
//    -> no stall; mem_wdata_fwd = 1 in sw's MEM cycle.
//  - Double producer: add r3 ; add r3 ; use r3
//    -> fwd_sel = 1 (youngest producer). With rd = 0: fwd_sel = 0.
//  - Freeze and reset: ext_stall for 3 cycles mid-hazard -> all outputs held/0 as specified,
//    same selects after release. rst mid-stream -> next cycle all fwd_sel = 0, hazard_stall = 0,
//    mem_wdata_fwd = 0.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// rtl/hazard_forward_ctrl_pkg.sv - forward-select encodings and shadow-stage record widths
package hazard_forward_ctrl_pkg;

    localparam int FWD_REGFILE = 0;
    localparam int FWD_EXMEM   = 1;
    localparam int FWD_MEMWB   = 2;

    // regwrite, memtoreg, memwrite
    localparam int REC_FLAGS_W = 3;

    function automatic int stage0_rec_w(input int ra_w, input int num_src);
        return ra_w + REC_FLAGS_W + num_src * (ra_w + 1);
    endfunction

    // stage 1 keeps rd, flags and the store-data source register
    function automatic int stage1_rec_w(input int ra_w);
        return 2 * ra_w + REC_FLAGS_W;
    endfunction

    // later stages only need rd, regwrite and memtoreg
    function automatic int stagek_rec_w(input int ra_w);
        return ra_w + 2;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// rtl/hazard_stage_reg.sv - one shadow-pipeline stage: hold, bubble insert, valid cleared on rst
module hazard_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold_i,
    input  logic         bubble_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            valid_q <= valid_i & ~bubble_i;
        end
    end

    // payload is only meaningful while valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (!hold_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX bypass selects, load-use stall and store-data bypass
// driven from a shadow pipeline of in-flight destination registers.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int RA_W      = 5,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NUM_SRC*RA_W-1:0]  id_src,
    input  logic [NUM_SRC-1:0]       id_src_used,
    input  logic [RA_W-1:0]          id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_memtoreg,
    input  logic                     id_memwrite,
    input  logic                     ext_stall,
    input  logic                     flush,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     hazard_stall,
    output logic                     mem_wdata_fwd
);

    logic [FWD_DEPTH:0]          st_v;
    logic [FWD_DEPTH:0]          st_rw;
    logic [FWD_DEPTH:0]          st_mtr;
    logic [RA_W-1:0]             st_rd [FWD_DEPTH+1];
    logic [NUM_SRC*RA_W-1:0]     s0_src;
    logic [NUM_SRC-1:0]          s0_used;
    logic                        s0_mw;
    logic                        s1_mw;
    logic [RA_W-1:0]             s1_src1;
    logic                        stall_raw;
    logic                        stall_int;

    for (genvar k = 0; k <= FWD_DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_s0
            localparam int W = stage0_rec_w(RA_W, NUM_SRC);
            logic [W-1:0] d;
            logic [W-1:0] q;
            assign d = {id_rd, id_regwrite, id_memtoreg, id_memwrite, id_src, id_src_used};
            hazard_stage_reg #(.W(W)) u_reg (
                .clk      (clk),
                .rst      (rst),
                .hold_i   (ext_stall),
                .bubble_i (flush | stall_int),
                .valid_i  (id_valid),
                .data_i   (d),
                .valid_o  (st_v[0]),
                .data_o   (q)
            );
            assign {st_rd[0], st_rw[0], st_mtr[0], s0_mw, s0_src, s0_used} = q;
        end else if (k == 1) begin : g_s1
            localparam int W = stage1_rec_w(RA_W);
            logic [W-1:0] d;
            logic [W-1:0] q;
            assign d = {st_rd[0], st_rw[0], st_mtr[0], s0_mw, s0_src[RA_W +: RA_W]};
            hazard_stage_reg #(.W(W)) u_reg (
                .clk      (clk),
                .rst      (rst),
                .hold_i   (ext_stall),
                .bubble_i (1'b0),
                .valid_i  (st_v[0]),
                .data_i   (d),
                .valid_o  (st_v[1]),
                .data_o   (q)
            );
            assign {st_rd[1], st_rw[1], st_mtr[1], s1_mw, s1_src1} = q;
        end else begin : g_sk
            localparam int W = stagek_rec_w(RA_W);
            logic [W-1:0] d;
            logic [W-1:0] q;
            assign d = {st_rd[k-1], st_rw[k-1], st_mtr[k-1]};
            hazard_stage_reg #(.W(W)) u_reg (
                .clk      (clk),
                .rst      (rst),
                .hold_i   (ext_stall),
                .bubble_i (1'b0),
                .valid_i  (st_v[k-1]),
                .data_i   (d),
                .valid_o  (st_v[k]),
                .data_o   (q)
            );
            assign {st_rd[k], st_rw[k], st_mtr[k]} = q;
        end
    end

    // a store whose data only depends on the load just ahead goes through mem_wdata_fwd instead
    always_comb begin
        stall_raw = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < LOAD_LAT; j++) begin
                if (id_src_used[i] && st_v[j] && st_mtr[j] && (st_rd[j] != '0) &&
                    (st_rd[j] == id_src[i*RA_W +: RA_W]) &&
                    !((j == 0) && (i == 1) && id_memwrite)) begin
                    stall_raw = 1'b1;
                end
            end
        end
    end

    assign stall_int    = id_valid & ~flush & ~ext_stall & stall_raw;
    assign hazard_stall = stall_int & ~rst;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        logic [RA_W-1:0]  src;
        logic [SEL_W-1:0] sel;
        logic             ld_pending;

        assign src = s0_src[i*RA_W +: RA_W];

        // scan oldest to youngest so the youngest producer is the last one kept
        always_comb begin
            sel        = SEL_W'(FWD_REGFILE);
            ld_pending = 1'b0;
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (st_v[k] && st_rw[k] && (st_rd[k] != '0) && (st_rd[k] == src)) begin
                    sel        = SEL_W'(k);
                    ld_pending = st_mtr[k] && (k <= LOAD_LAT);
                end
            end
        end

        assign fwd_sel[i*SEL_W +: SEL_W] =
            (rst || !st_v[0] || !s0_used[i] || ld_pending) ? SEL_W'(FWD_REGFILE) : sel;
    end

    assign mem_wdata_fwd = ~rst & st_v[FWD_EXMEM] & s1_mw &
                           st_v[FWD_MEMWB] & st_mtr[FWD_MEMWB] &
                           (st_rd[FWD_MEMWB] != '0) & (st_rd[FWD_MEMWB] == s1_src1);

endmodule
